mips_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences fetch, decode, execute, memory and writeback for the MIPS-subset datapath.
- Consumes the registered opcode and func fields from the instruction decoder, plus ALU zero and memory/fetch acknowledges.
- Drives every datapath enable and select, one instruction at a time.
- Sits between the instruction memory interface and the register file, ALU and PC.

---
 rtl/ctrl_pkg.sv | 38 +++
 rtl/mips_multicycle_ctrl_if.sv | 25 ++
 rtl/ctrl_alu_dec.sv | 39 +++
 rtl/mips_multicycle_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the MIPS-subset multi-cycle controller:
// FSM states, instruction opcode/func fields and ALU operation codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_NOP  = 4'd15;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Instruction/data memory handshake between the controller (master) and the
// memory side (slave): request strobes out, acknowledges back.
interface mips_multicycle_ctrl_if;
    logic fetch_req;
    logic fetch_ack;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (
        output fetch_req,
        output mem_req,
        output mem_we,
        input  fetch_ack,
        input  mem_ack
    );

    modport slave (
        input  fetch_req,
        input  mem_req,
        input  mem_we,
        output fetch_ack,
        output mem_ack
    );
endinterface

// File: rtl/ctrl_alu_dec.sv
// Combinational opcode/func decode into ALU operation, immediate-operand
// select and a legality flag for the supported instruction subset.
module ctrl_alu_dec
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output logic [3:0] alu_op,
    output logic       alu_src_imm,
    output logic       legal
);

    always_comb begin
        alu_op      = ALU_NOP;
        alu_src_imm = 1'b0;
        legal       = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    default: legal  = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                alu_op      = ALU_ADD;
                alu_src_imm = 1'b1;
            end
            OP_BEQ:        alu_op = ALU_SUB;
            OP_J, OP_HALT: alu_op = ALU_NOP;
            default:       legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath (fetch/decode/exec/mem/wb).
// Define CTRL_PERF_CNT_EN to build the retired-instruction counter; otherwise retired is 0.
//
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | fetch_req high until fetch_ack, ir_load on the ack cycle
//   DECODE | one cycle for the decoder to register IR fields
//   EXEC   | ALU operation; beq/j/halt resolve here
//   MEM    | data access for lw/sw, waiting on mem_ack
//   WB     | register file write, PC += 4
//   HALT   | terminal; only reset leaves
module mips_multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [5:0]             opcode,
    input  logic [5:0]             func,
    input  logic                   alu_zero,
    mips_multicycle_ctrl_if.master bus,
    output logic                   ir_load,
    output logic [3:0]             alu_op,
    output logic                   alu_src_imm,
    output logic                   rf_we,
    output logic                   rf_dst_rd,
    output logic                   rf_src_mem,
    output logic                   pc_inc,
    output logic                   pc_branch,
    output logic                   pc_jump,
    output logic                   busy,
    output logic                   halted,
    output logic                   illegal,
    output logic                   bus_err,
    output logic [CNT_W-1:0]       retired
);

    localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

    state_t           state;
    logic [TMR_W-1:0] timer;

    logic [3:0] dec_alu_op;
    logic       dec_src_imm;
    logic       dec_legal;

    logic fetch_req_w;
    logic mem_req_w;
    logic mem_we_w;
    logic retire;

    logic is_rtype;
    logic is_lw;
    logic is_sw;

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);

    ctrl_alu_dec u_alu_dec (
        .opcode      (opcode),
        .func        (func),
        .alu_op      (dec_alu_op),
        .alu_src_imm (dec_src_imm),
        .legal       (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                        timer <= '0;
                    end
                end
                FETCH: begin
                    // an ack landing on the last allowed cycle still wins
                    if (bus.fetch_ack) begin
                        state <= DECODE;
                    end else if (timer == TMR_LAST) begin
                        bus_err <= 1'b1;
                        halted  <= 1'b1;
                        state   <= HALT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                DECODE: state <= EXEC;
                EXEC: begin
                    timer <= '0;
                    if (!dec_legal) begin
                        illegal <= 1'b1;
                        halted  <= 1'b1;
                        state   <= HALT;
                    end else begin
                        case (opcode)
                            OP_LW, OP_SW: state <= MEM;
                            OP_BEQ, OP_J: state <= FETCH;
                            OP_HALT: begin
                                halted <= 1'b1;
                                state  <= HALT;
                            end
                            default:      state <= WB;
                        endcase
                    end
                end
                MEM: begin
                    if (bus.mem_ack) begin
                        timer <= '0;
                        state <= is_lw ? WB : FETCH;
                    end else if (timer == TMR_LAST) begin
                        bus_err <= 1'b1;
                        halted  <= 1'b1;
                        state   <= HALT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                WB: begin
                    timer <= '0;
                    state <= FETCH;
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    // Enables follow the state; ir_load, the beq PC select and the sw PC
    // increment also track the same-cycle ack/zero inputs.
    always_comb begin
        fetch_req_w = 1'b0;
        mem_req_w   = 1'b0;
        mem_we_w    = 1'b0;
        ir_load     = 1'b0;
        alu_op      = ALU_NOP;
        alu_src_imm = 1'b0;
        rf_we       = 1'b0;
        rf_dst_rd   = 1'b0;
        rf_src_mem  = 1'b0;
        pc_inc      = 1'b0;
        pc_branch   = 1'b0;
        pc_jump     = 1'b0;
        retire      = 1'b0;
        case (state)
            FETCH: begin
                fetch_req_w = 1'b1;
                ir_load     = bus.fetch_ack;
            end
            EXEC: begin
                alu_op      = dec_alu_op;
                alu_src_imm = dec_src_imm;
                if (dec_legal) begin
                    case (opcode)
                        OP_BEQ: begin
                            pc_branch = alu_zero;
                            pc_inc    = ~alu_zero;
                            retire    = 1'b1;
                        end
                        OP_J: begin
                            pc_jump = 1'b1;
                            retire  = 1'b1;
                        end
                        OP_HALT: retire = 1'b1;
                        default: retire = 1'b0;
                    endcase
                end
            end
            MEM: begin
                mem_req_w = 1'b1;
                mem_we_w  = is_sw;
                if (bus.mem_ack && is_sw) begin
                    pc_inc = 1'b1;
                    retire = 1'b1;
                end
            end
            WB: begin
                rf_we      = 1'b1;
                rf_dst_rd  = is_rtype;
                rf_src_mem = is_lw;
                pc_inc     = 1'b1;
                retire     = 1'b1;
            end
            default: retire = 1'b0;
        endcase
    end

    assign bus.fetch_req = fetch_req_w;
    assign bus.mem_req   = mem_req_w;
    assign bus.mem_we    = mem_we_w;
    assign busy          = (state != IDLE) && (state != HALT);

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_W'(1);
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign retired       = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed and randomized instructions checked
// against an instruction-level model of latency, enables and sticky flags.
module tb_mips_multicycle_ctrl;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        alu_zero;
    logic        ir_load;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        rf_we;
    logic        rf_dst_rd;
    logic        rf_src_mem;
    logic        pc_inc;
    logic        pc_branch;
    logic        pc_jump;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic        bus_err;
    logic [31:0] retired;

    mips_multicycle_ctrl_if bus_if ();

    mips_multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .opcode      (opcode),
        .func        (func),
        .alu_zero    (alu_zero),
        .bus         (bus_if.master),
        .ir_load     (ir_load),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .rf_we       (rf_we),
        .rf_dst_rd   (rf_dst_rd),
        .rf_src_mem  (rf_src_mem),
        .pc_inc      (pc_inc),
        .pc_branch   (pc_branch),
        .pc_jump     (pc_jump),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .bus_err     (bus_err),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int exp_retired = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [31:0] exp_ret();
`ifdef CTRL_PERF_CNT_EN
        return exp_retired;
`else
        return 32'd0;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        bus_if.fetch_ack = 1'b0;
        bus_if.mem_ack = 1'b0;
        @(posedge clk);
        #1;
        exp_retired = 0;
        chk("rst_enables", {17'd0, bus_if.fetch_req, ir_load, alu_src_imm, bus_if.mem_req,
             bus_if.mem_we, rf_we, rf_dst_rd, rf_src_mem, pc_inc, pc_branch, pc_jump,
             busy, halted, illegal, bus_err}, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd15);
        chk("rst_retired", retired, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        bus_if.fetch_ack = 1'b0;
        bus_if.mem_ack = 1'b0;
    endtask

    // fwait/mwait: ack on that cycle of the request (0 = never acknowledged)
    task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input int fwait, input int mwait, input logic zero);
        int cyc = 0, fcnt = 0, mcnt = 0, irl = 0, irl_ack = 0, rfw = 0, dst = 0, srcm = 0;
        int mwe = 0, busyc = 0, multi = 0, pcact = 0, aluop = 15, imm = 0, sel;
        bit done = 0;
        bit legal = 1, mem_op, fto, to, halting, is_r, is_lw;
        int e_alu = 15, e_imm = 0, e_cyc, e_irl, e_mreq = 0, e_mwe, e_rfw, e_pc;

        is_r   = (op == 6'h00);
        is_lw  = (op == 6'h23);
        mem_op = is_lw || (op == 6'h2B);
        case (op)
            6'h00: case (fn)
                6'h20: e_alu = 0;
                6'h22: e_alu = 1;
                6'h24: e_alu = 2;
                6'h25: e_alu = 3;
                6'h2A: e_alu = 4;
                6'h00: e_alu = 5;
                default: legal = 0;
            endcase
            6'h08, 6'h23, 6'h2B: begin e_alu = 0; e_imm = 1; end
            6'h04: e_alu = 1;
            6'h02, 6'h3F: e_alu = 15;
            default: legal = 0;
        endcase
        fto = (fwait == 0);
        to = fto || (legal && mem_op && mwait == 0);
        halting = to || !legal || op == 6'h3F;
        e_irl = fto ? 0 : 1;
        if (fto) begin
            e_cyc = T + 1;
            e_alu = 15;
            e_imm = 0;
        end else if (!legal || op == 6'h3F) begin
            e_cyc = fwait + 3;
        end else if (mem_op) begin
            e_mreq = (mwait == 0) ? T : mwait;
            e_cyc = (mwait == 0) ? fwait + T + 3 : fwait + mwait + (is_lw ? 3 : 2);
        end else if (op == 6'h04 || op == 6'h02) begin
            e_cyc = fwait + 2;
        end else begin
            e_cyc = fwait + 3;
        end
        e_mwe = (op == 6'h2B) ? e_mreq : 0;
        e_rfw = (!halting && (is_r || op == 6'h08 || is_lw)) ? 1 : 0;
        e_pc = halting ? 0 : (op == 6'h04) ? (zero ? 2 : 1) : (op == 6'h02) ? 3 : 1;

        while (!done && cyc < 100) begin
            @(negedge clk);
            opcode = op;
            func = fn;
            alu_zero = zero;
            start = 1'($urandom_range(0, 1));
            bus_if.fetch_ack = bus_if.fetch_req && (fcnt + 1 == fwait);
            bus_if.mem_ack = bus_if.mem_req && (mcnt + 1 == mwait);
            #1;
            cyc++;
            if (halted) begin
                done = 1;
            end else begin
                if (bus_if.fetch_req) fcnt++;
                if (bus_if.mem_req) mcnt++;
                if (bus_if.mem_we) mwe++;
                if (ir_load) irl++;
                if (ir_load && bus_if.fetch_ack) irl_ack++;
                if (rf_we) begin rfw++; dst = rf_dst_rd; srcm = rf_src_mem; end
                if (busy) busyc++;
                if (alu_op != 4'd15) begin aluop = alu_op; imm = alu_src_imm; end
                sel = int'(pc_inc) + int'(pc_branch) + int'(pc_jump);
                if (sel > 1) multi++;
                if (sel != 0) begin
                    pcact = pc_inc ? 1 : pc_branch ? 2 : 3;
                    done = 1;
                end
            end
        end
        if (legal && !to) exp_retired++;

        chk({nm, " cycles"}, cyc, e_cyc);
        chk({nm, " ir_load"}, irl, e_irl);
        chk({nm, " ir_load_on_ack"}, irl_ack, e_irl);
        chk({nm, " alu_op"}, aluop, e_alu);
        chk({nm, " alu_src_imm"}, imm, e_imm);
        chk({nm, " rf_we"}, rfw, e_rfw);
        chk({nm, " rf_dst_rd"}, dst, (e_rfw == 1 && is_r) ? 1 : 0);
        chk({nm, " rf_src_mem"}, srcm, (e_rfw == 1 && is_lw) ? 1 : 0);
        chk({nm, " mem_req_cycles"}, mcnt, e_mreq);
        chk({nm, " mem_we_cycles"}, mwe, e_mwe);
        chk({nm, " pc_action"}, pcact, e_pc);
        chk({nm, " pc_multi"}, multi, 0);
        chk({nm, " busy_cycles"}, busyc, halting ? e_cyc - 1 : e_cyc);
        @(posedge clk);
        #1;
        chk({nm, " halted"}, {31'd0, halted}, {31'd0, halting});
        chk({nm, " illegal"}, {31'd0, illegal}, {31'd0, !legal && !fto});
        chk({nm, " bus_err"}, {31'd0, bus_err}, {31'd0, to});
        chk({nm, " busy_after"}, {31'd0, busy}, {31'd0, !halting});
        chk({nm, " retired"}, retired, exp_ret());
    endtask

    task automatic run_random(input int n);
        logic [5:0] rfn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        logic [5:0] ops [5] = '{6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
        for (int i = 0; i < n; i++) begin
            int k;
            logic [5:0] op, fn;
            k = $urandom_range(0, 10);
            fn = 6'($urandom_range(0, 63));
            if (k < 6) begin
                op = 6'h00;
                fn = rfn[k];
            end else begin
                op = ops[k-6];
            end
            run_instr($sformatf("rnd%0d_op%0h", i, op), op, fn, $urandom_range(1, 5),
                      $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_mem;
        reset = 1'b0;
        start = 1'b0;
        opcode = 6'h00;
        func = 6'h00;
        alu_zero = 1'b0;
        bus_if.fetch_ack = 1'b0;
        bus_if.mem_ack = 1'b0;

        do_reset();
        do_start();
        run_instr("add", 6'h00, 6'h20, 3, 1, 1'b0);
        run_instr("lw", 6'h23, 6'h00, 1, 3, 1'b0);
        run_instr("beq_taken", 6'h04, 6'h00, 2, 1, 1'b1);
        run_instr("beq_not", 6'h04, 6'h00, 1, 1, 1'b0);
        run_instr("sw", 6'h2B, 6'h00, 2, 2, 1'b0);
        run_instr("j_ack16", 6'h02, 6'h00, T, 1, 1'b0);
        run_random(40);
        run_instr("illegal_op", 6'h15, 6'h00, 2, 1, 1'b0);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("halt_hold busy", {31'd0, busy}, 32'd0);
        chk("halt_hold fetch_req", {31'd0, bus_if.fetch_req}, 32'd0);
        chk("halt_hold halted", {31'd0, halted}, 32'd1);
        chk("halt_hold retired", retired, exp_ret());

        do_reset();
        do_start();
        run_instr("fetch_timeout", 6'h08, 6'h00, 0, 1, 1'b0);
        do_reset();
        do_start();
        run_instr("mem_timeout", 6'h23, 6'h00, 2, 0, 1'b0);
        do_reset();
        do_start();
        run_instr("bad_func", 6'h00, 6'h21, 1, 1, 1'b0);
        do_reset();
        do_start();
        run_random(10);
        run_instr("halt_op", 6'h3F, 6'h00, 2, 1, 1'b0);

        do_reset();
        do_start();
        seen_mem = 0;
        for (int i = 0; i < 20 && !seen_mem; i++) begin
            @(negedge clk);
            start = 1'b0;
            opcode = 6'h2B;
            func = 6'h00;
            bus_if.fetch_ack = bus_if.fetch_req;
            bus_if.mem_ack = 1'b0;
            #1;
            if (bus_if.mem_req) seen_mem = 1;
        end
        chk("midmem reached", {31'd0, seen_mem}, 32'd1);
        do_reset();
        @(negedge clk);
        #1;
        chk("midmem stays_idle", {30'd0, busy, bus_if.fetch_req}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
